// File: rtl/exu_div_if.sv
// Handshake and operand bundle between the issue stage and the sequential divider.
interface exu_div_if;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        start_i;
    logic [3:0]  op_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;

    modport master (
        output dividend_i, divisor_i, start_i, op_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  dividend_i, divisor_i, start_i, op_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/exu_div_seq.sv
// Sequential radix-2 restoring divider for div/divu/rem/remu, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish one cycle after acceptance.
module exu_div_seq (
    input  logic         clk,
    input  logic         rst_n,
    exu_div_if.slave     dif
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_END} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] divisor_q;
    logic [31:0] quo_q;
    logic [32:0] rem_q;
    logic        op_rem_q;
    logic        neg_quo_q;
    logic        neg_rem_q;

    logic        accept;
    logic        sel_signed;
    logic        sel_rem;
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic        ovf;
    logic        special;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [33:0] rem_shift;
    logic [33:0] rem_diff;
    logic        step_ge;
    logic        busy;
    logic        step_en;
    logic        finish_en;

    function automatic logic [31:0] fix_sign(input logic [31:0] v, input logic neg);
        logic signed [31:0] sv;
        sv = $signed(v);
        return neg ? 32'(-sv) : v;
    endfunction

    // Priority decode: div > divu > rem > remu.
    always_comb begin
        sel_signed = 1'b0;
        sel_rem    = 1'b1;
        if (dif.op_i[3]) begin
            sel_signed = 1'b1;
            sel_rem    = 1'b0;
        end else if (dif.op_i[2]) begin
            sel_signed = 1'b0;
            sel_rem    = 1'b0;
        end else if (dif.op_i[1]) begin
            sel_signed = 1'b1;
            sel_rem    = 1'b1;
        end
    end

    assign accept   = (state_q == S_IDLE) && dif.start_i && (dif.op_i != 4'b0000) && !dif.ready_o;
    assign a_neg    = sel_signed & dif.dividend_i[31];
    assign b_neg    = sel_signed & dif.divisor_i[31];
    assign a_mag    = fix_sign(dif.dividend_i, a_neg);
    assign b_mag    = fix_sign(dif.divisor_i, b_neg);
    assign div_zero = (dif.divisor_i == 32'h0000_0000);
    assign ovf      = sel_signed && (dif.dividend_i == 32'h8000_0000) && (dif.divisor_i == 32'hFFFF_FFFF);
    assign special  = div_zero | ovf;

    // The shifted partial remainder never exceeds 33 bits; bit 33 of the difference is the borrow.
    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_diff  = rem_shift - {2'b00, divisor_q};
    assign step_ge   = ~rem_diff[33];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = special ? S_END : S_CALC;
            S_CALC: begin
                if (!dif.start_i)        state_d = S_IDLE;
                else if (cnt_q == 5'd31) state_d = S_END;
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        step_en   = (state_q == S_CALC) && dif.start_i;
        finish_en = (state_q == S_END) && dif.start_i;
    end

    assign dif.busy_o = busy;

    // Operand latch and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 5'd0;
            divisor_q <= 32'd0;
            quo_q     <= 32'd0;
            rem_q     <= 33'd0;
            op_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            cnt_q    <= 5'd0;
            op_rem_q <= sel_rem;
            if (special) begin
                divisor_q <= 32'd0;
                quo_q     <= div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
                rem_q     <= div_zero ? {1'b0, dif.dividend_i} : 33'd0;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
            end else begin
                divisor_q <= b_mag;
                quo_q     <= a_mag;
                rem_q     <= 33'd0;
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
            end
        end else if (step_en) begin
            cnt_q <= cnt_q + 5'd1;
            quo_q <= {quo_q[30:0], step_ge};
            rem_q <= step_ge ? rem_diff[32:0] : rem_shift[32:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dif.result_o <= 32'd0;
            dif.ready_o  <= 1'b0;
        end else if (finish_en) begin
            dif.result_o <= op_rem_q ? fix_sign(rem_q[31:0], neg_rem_q) : fix_sign(quo_q, neg_quo_q);
            dif.ready_o  <= 1'b1;
        end else begin
            dif.result_o <= 32'd0;
            dif.ready_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exu_div_seq.sv
// Scoreboard bench for exu_div_seq: directed and model-checked operations, abort and reset cases.
module tb_exu_div_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exu_div_if dif();

    exu_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        int          id;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   op_id  = 0;

    localparam logic [3:0] OP_DIV  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REM  = 4'b0010;
    localparam logic [3:0] OP_REMU = 4'b0001;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic int op_sel(input logic [3:0] op);
        if (op[3]) return 0;
        if (op[2]) return 1;
        if (op[1]) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = op_sel(op);
        if (b == 32'd0) return (s == 0 || s == 1) ? 32'hFFFF_FFFF : a;
        if ((s == 0 || s == 2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (s == 0) ? 32'h8000_0000 : 32'd0;
        case (s)
            0:       return 32'($signed(a) / $signed(b));
            1:       return a / b;
            2:       return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = op_sel(op);
        if (b == 32'd0) return 1;
        if ((s == 0 || s == 2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Monitor: pops one expectation per ready pulse and checks the cycle after it.
    logic prev_ready = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_ready) begin
                check("ready_single_pulse", 32'(dif.ready_o), 32'd0);
                check("result_cleared_after_ready", dif.result_o, 32'd0);
            end
            if (dif.ready_o) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check($sformatf("result_op%0d", mon_e.id), dif.result_o, mon_e.res);
                    check($sformatf("latency_op%0d", mon_e.id), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                end
            end
        end
        prev_ready = dif.ready_o;
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit scramble);
        int n;
        exp_t e;
        @(negedge clk);
        dif.op_i       = op;
        dif.dividend_i = a;
        dif.divisor_i  = b;
        dif.start_i    = 1'b1;
        @(posedge clk);
        #1;
        e.res = ref_res(op, a, b);
        e.lat = ref_lat(op, a, b);
        e.acc = cyc;
        e.id  = op_id;
        op_id++;
        sbq.push_back(e);
        if (scramble) begin
            dif.dividend_i = $urandom;
            dif.divisor_i  = $urandom;
            dif.op_i       = 4'($urandom);
        end
        n = 0;
        while (!dif.ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!dif.ready_o) check("ready_timeout", 32'd0, 32'd1);
        dif.start_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [3:0]  op;
        logic [31:0] a, b;

        dif.start_i    = 1'b0;
        dif.op_i       = 4'b0000;
        dif.dividend_i = 32'd0;
        dif.divisor_i  = 32'd0;

        #12;
        check("reset_busy", 32'(dif.busy_o), 32'd0);
        check("reset_ready", 32'(dif.ready_o), 32'd0);
        check("reset_result", dif.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Request with no op selected must be ignored.
        dif.op_i    = 4'b0000;
        dif.start_i = 1'b1;
        repeat (5) @(negedge clk);
        check("no_op_busy", 32'(dif.busy_o), 32'd0);
        dif.start_i = 1'b0;

        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(OP_DIV,  32'd5, 32'd0, 1'b0);
        run_op(OP_REM,  32'd5, 32'd0, 1'b0);
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_DIV,  32'h8000_0000, 32'd1, 1'b1);
        run_op(4'b1111, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(4'b0011, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(4'b0110, 32'd1000, 32'd3, 1'b0);
        run_op(OP_REMU, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 1'b0);

        // Abort: drop start ten cycles into the operation.
        @(negedge clk);
        dif.op_i       = OP_DIVU;
        dif.dividend_i = 32'd1000;
        dif.divisor_i  = 32'd3;
        dif.start_i    = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy_low", 32'(dif.busy_o), 32'd0);
        r = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.ready_o) r++;
        end
        check("abort_no_ready", 32'(r), 32'd0);
        run_op(OP_DIVU, 32'd1000, 32'd3, 1'b0);

        // Asynchronous reset in the middle of a signed divide.
        @(negedge clk);
        dif.op_i       = OP_DIV;
        dif.dividend_i = 32'h1234_5678;
        dif.divisor_i  = 32'h0000_0321;
        dif.start_i    = 1'b1;
        @(posedge clk);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(dif.busy_o), 32'd0);
        check("async_reset_ready", 32'(dif.ready_o), 32'd0);
        check("async_reset_result", dif.result_o, 32'd0);
        dif.start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        r = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.ready_o) r++;
        end
        check("post_reset_no_ready", 32'(r), 32'd0);

        // Back-to-back mixed operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            op = 4'b0001 << $urandom_range(0, 3);
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                default: b = $urandom;
            endcase
            run_op(op, a, b, i[0]);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
